// File: rtl/dtree_pkg.sv
// ----------------------------------------------------------------------------
// dtree_pkg
// Shared definitions for the decision-tree feature loader:
//   - loader_state_e : LOAD / SETTLE / RESULT states of the loader FSM
//   - FEAT_W_DEF, CLASS_W_DEF : default feature and class widths
//   - NUM_FEATURES_DEF : feature count of the current dataset's tree
//   - idx_width() : index width helper that stays legal for a 1-entry vector
// ----------------------------------------------------------------------------
package dtree_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESULT = 2'd2
   } loader_state_e;

   localparam int FEAT_W_DEF       = 8;
   localparam int CLASS_W_DEF      = 5;
   localparam int NUM_FEATURES_DEF = 45;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dtree_feat_regfile.sv
// ----------------------------------------------------------------------------
// dtree_feat_regfile
// NUM_FEATURES x FEAT_W feature register file exposed as one flat bus.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, clears every slot
//   we_i    in   write enable
//   widx_i  in   slot to write
//   wdata_i in   feature byte to store
//   bus_o   out  flat bus, slot k at bits [k*FEAT_W +: FEAT_W]
// ----------------------------------------------------------------------------
module dtree_feat_regfile
   import dtree_pkg::*;
#(
   parameter int NUM_FEATURES = NUM_FEATURES_DEF,
   parameter int FEAT_W       = FEAT_W_DEF,
   parameter int IDX_W        = idx_width(NUM_FEATURES)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we_i,
   input  logic [IDX_W-1:0]               widx_i,
   input  logic [FEAT_W-1:0]              wdata_i,
   output logic [NUM_FEATURES*FEAT_W-1:0] bus_o
);

   logic [FEAT_W-1:0] slot_q [NUM_FEATURES];

   for (genvar k = 0; k < NUM_FEATURES; k++) begin : g_slot
      always_ff @(posedge clk) begin
         if (rst) begin
            slot_q[k] <= '0;
         end else if (we_i && (widx_i == IDX_W'(k))) begin
            slot_q[k] <= wdata_i;
         end
      end
      assign bus_o[k*FEAT_W +: FEAT_W] = slot_q[k];
   end

endmodule

// File: rtl/dtree_feature_loader.sv
// ----------------------------------------------------------------------------
// dtree_feature_loader
// Collects one feature byte per handshake into a parallel vector, holds the
// vector on the tree inputs for SETTLE_CYCLES, samples the tree's class and
// offers it on a valid/ready handshake.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   s_valid   in   feature byte valid
//   s_ready   out  loader accepts a byte (only in LOAD)
//   s_data    in   feature byte; feature k is the k-th accepted byte
//   s_last    in   final byte of a vector
//   feat_bus  out  assembled vector, feature k at [k*FEAT_W +: FEAT_W]
//   class_in  in   tree class output, combinational from feat_bus
//   m_valid   out  class result valid
//   m_ready   in   downstream accepts the result
//   m_class   out  registered class result
//   err_len   out  one-cycle pulse on a vector length mismatch
// ----------------------------------------------------------------------------
module dtree_feature_loader
   import dtree_pkg::*;
#(
   parameter int NUM_FEATURES  = NUM_FEATURES_DEF,
   parameter int FEAT_W        = FEAT_W_DEF,
   parameter int CLASS_W       = CLASS_W_DEF,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [FEAT_W-1:0]              s_data,
   input  logic                           s_last,
   output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
   input  logic [CLASS_W-1:0]             class_in,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [CLASS_W-1:0]             m_class,
   output logic                           err_len
);

   localparam int IDX_W = idx_width(NUM_FEATURES);
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

   loader_state_e      state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               drop_q, drop_d;
   logic               err_q, err_d;
   logic               mvalid_q, mvalid_d;
   logic [CLASS_W-1:0] mclass_q, mclass_d;
   logic               we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         idx_q    <= '0;
         cnt_q    <= '0;
         drop_q   <= 1'b0;
         err_q    <= 1'b0;
         mvalid_q <= 1'b0;
         mclass_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         drop_q   <= drop_d;
         err_q    <= err_d;
         mvalid_q <= mvalid_d;
         mclass_q <= mclass_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      drop_d   = drop_q;
      err_d    = 1'b0;
      mvalid_d = mvalid_q;
      mclass_d = mclass_q;
      we       = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (s_valid) begin
               if (drop_q) begin
                  // Over-long vector: swallow bytes up to and including its
                  // s_last without storing them or flagging again.
                  if (s_last) begin
                     drop_d = 1'b0;
                  end
               end else begin
                  we = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     idx_d = '0;
                     if (s_last) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_INIT;
                     end else begin
                        err_d  = 1'b1;
                        drop_d = 1'b1;
                     end
                  end else if (s_last) begin
                     err_d = 1'b1;
                     idx_d = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
         end

         ST_SETTLE: begin
            // The class is sampled in the cycle the counter reads zero, so
            // the vector has been stable for SETTLE_CYCLES full cycles.
            if (cnt_q == '0) begin
               mclass_d = class_in;
               mvalid_d = 1'b1;
               state_d  = ST_RESULT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_RESULT: begin
            if (m_ready) begin
               mvalid_d = 1'b0;
               idx_d    = '0;
               state_d  = ST_LOAD;
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // s_ready is 1 in LOAD only, which also makes the vector frozen elsewhere.
   assign s_ready = (state_q == ST_LOAD);
   assign m_valid = mvalid_q;
   assign m_class = mclass_q;
   assign err_len = err_q;

   dtree_feat_regfile #(
      .NUM_FEATURES (NUM_FEATURES),
      .FEAT_W       (FEAT_W),
      .IDX_W        (IDX_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we && s_ready),
      .widx_i  (idx_q),
      .wdata_i (s_data),
      .bus_o   (feat_bus)
   );

endmodule

// File: tb/tb_dtree_feature_loader.sv
module tb_dtree_feature_loader;

   localparam int NF = 45;
   localparam int FW = 8;
   localparam int CW = 5;
   localparam int SC = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_last = 1'b0;
   logic              m_ready = 1'b0;
   logic [FW-1:0]     s_data = '0;
   logic              s_ready, m_valid, err_len;
   logic [NF*FW-1:0]  feat_bus;
   logic [CW-1:0]     class_in, m_class;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   logic [CW-1:0] sb [$];
   logic [FW-1:0] vec [0:63];

   always #5 clk = ~clk;

   // Tree stub
   assign class_in = (feat_bus[13*FW +: FW] == '0) ? CW'(13) : CW'(3);

   dtree_feature_loader #(
      .NUM_FEATURES  (NF),
      .FEAT_W        (FW),
      .CLASS_W       (CW),
      .SETTLE_CYCLES (SC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .feat_bus (feat_bus),
      .class_in (class_in),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_class  (m_class),
      .err_len  (err_len)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Result scoreboard: every completed handshake must match the oldest
   // expectation pushed by the stimulus.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected_result observed=%0h expected=none", m_class);
         end
         if (sb.size() != 0) chk("sb_class", m_class, sb.pop_front());
      end
      if (!rst && err_len) err_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [CW-1:0] cls_exp();
      return (vec[13] == '0) ? CW'(13) : CW'(3);
   endfunction

   function automatic logic [NF*FW-1:0] exp_bus();
      logic [NF*FW-1:0] b;
      b = '0;
      for (int k = 0; k < NF; k++) b[k*FW +: FW] = vec[k];
      return b;
   endfunction

   task automatic fill(input int mode);
      for (int i = 0; i < 64; i++) begin
         case (mode)
            0:       vec[i] = FW'(i + 1);
            1:       vec[i] = (i == 13) ? '0 : FW'(i + 1);
            default: vec[i] = FW'(i * 7 + 3);
         endcase
      end
   endtask

   // Called #1 after a posedge; returns #1 after the accepting posedge.
   task automatic send_byte(input logic [FW-1:0] d, input logic last);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("send_byte_timeout", (n >= 200), 0);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_vec(input int n, input int last_idx, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(posedge clk);
               #1;
            end
         end
         send_byte(vec[i], i == last_idx);
      end
   endtask

   // Clocks from the accepting edge of the last byte (that edge counts as 1)
   // until m_valid is seen high.
   task automatic wait_result(output int lat);
      lat = 1;
      while (m_valid !== 1'b1 && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int e0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_class", m_class, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_feat_bus", feat_bus, 0);
      chk("rst_s_ready", s_ready, 1);

      // Nominal vector
      fill(0);
      m_ready = 1'b1;
      e0 = err_cnt;
      sb.push_back(cls_exp());
      send_vec(NF, NF - 1, 1'b0);
      wait_result(lat);
      chk("nom_latency", lat, SC + 1);
      chk("nom_class", m_class, 3);
      chk("nom_slot44", feat_bus[44*FW +: FW], 45);
      chk("nom_bus", feat_bus, exp_bus());
      @(posedge clk);
      #1;
      chk("nom_mvalid_drop", m_valid, 0);
      chk("nom_s_ready", s_ready, 1);
      chk("nom_no_err", err_cnt - e0, 0);

      // Backpressure
      fill(1);
      m_ready = 1'b0;
      sb.push_back(cls_exp());
      send_vec(NF, NF - 1, 1'b0);
      wait_result(lat);
      chk("bp_latency", lat, SC + 1);
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = 8'hEE;
         s_last  = 1'b1;
         @(posedge clk);
         #1;
         chk("bp_m_valid", m_valid, 1);
         chk("bp_m_class", m_class, 13);
         chk("bp_s_ready", s_ready, 0);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("bp_bus_frozen", feat_bus, exp_bus());
      chk("bp_no_err", err_cnt - e0, 0);
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_mvalid_drop", m_valid, 0);
      chk("bp_s_ready_back", s_ready, 1);

      // Short vector
      fill(2);
      e0 = err_cnt;
      send_vec(21, 20, 1'b0);
      chk("short_err_pulse", err_len, 1);
      @(posedge clk);
      #1;
      chk("short_err_single", err_len, 0);
      chk("short_no_mvalid", m_valid, 0);
      chk("short_s_ready", s_ready, 1);
      chk("short_err_count", err_cnt - e0, 1);
      sb.push_back(cls_exp());
      send_vec(NF, NF - 1, 1'b0);
      wait_result(lat);
      chk("short_next_latency", lat, SC + 1);
      chk("short_next_bus", feat_bus, exp_bus());
      @(posedge clk);
      #1;
      chk("short_next_err_count", err_cnt - e0, 1);

      // Long vector
      fill(1);
      e0 = err_cnt;
      send_vec(NF, -1, 1'b0);
      chk("long_err_pulse", err_len, 1);
      for (int i = NF; i < 50; i++) send_byte(vec[i], i == 49);
      chk("long_no_second_err", err_len, 0);
      chk("long_err_count", err_cnt - e0, 1);
      chk("long_s_ready", s_ready, 1);
      chk("long_dropped_bus", feat_bus, exp_bus());
      chk("long_no_mvalid", m_valid, 0);
      fill(0);
      sb.push_back(cls_exp());
      send_vec(NF, NF - 1, 1'b0);
      wait_result(lat);
      chk("long_next_latency", lat, SC + 1);
      chk("long_next_class", m_class, 3);
      chk("long_next_bus", feat_bus, exp_bus());
      @(posedge clk);
      #1;
      chk("long_next_err_count", err_cnt - e0, 1);

      // Gapped input
      fill(0);
      sb.push_back(cls_exp());
      send_vec(NF, NF - 1, 1'b1);
      wait_result(lat);
      chk("gap_latency", lat, SC + 1);
      chk("gap_class", m_class, 3);
      chk("gap_bus", feat_bus, exp_bus());
      @(posedge clk);
      #1;

      // Reset during SETTLE
      fill(2);
      send_vec(NF, NF - 1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_settle_m_valid", m_valid, 0);
      chk("rst_settle_bus", feat_bus, 0);
      chk("rst_settle_s_ready", s_ready, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_settle_no_stale", m_valid, 0);

      // Reset during RESULT
      m_ready = 1'b0;
      send_vec(NF, NF - 1, 1'b0);
      wait_result(lat);
      chk("rst_result_latency", lat, SC + 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_result_m_valid", m_valid, 0);
      chk("rst_result_bus", feat_bus, 0);
      chk("rst_result_s_ready", s_ready, 1);
      chk("rst_result_m_class", m_class, 0);
      m_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_result_no_stale", m_valid, 0);

      // Recovery vector after the resets
      fill(1);
      sb.push_back(cls_exp());
      send_vec(NF, NF - 1, 1'b0);
      wait_result(lat);
      chk("final_latency", lat, SC + 1);
      chk("final_class", m_class, 13);
      @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
